// File: rtl/pixel_fb_pkg.sv
// -----------------------------------------------------------------------------
// pixel_fb_pkg
// Shared definitions for the pixel framebuffer writer:
//   - screen geometry and framebuffer size
//   - address / colour widths
//   - writer FSM state encoding
//   - plot FIFO entry layout {addr, colour}
//   - fb_addr(): linear address y*160 + x built from shifts and an add
// -----------------------------------------------------------------------------
package pixel_fb_pkg;

    localparam int SCREEN_W = 160;
    localparam int SCREEN_H = 120;
    localparam int FB_WORDS = SCREEN_W * SCREEN_H;   // 19200
    localparam int ADDR_W   = 15;
    localparam int COLOUR_W = 3;
    localparam int ENTRY_W  = ADDR_W + COLOUR_W;     // 18

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_CLEAR = 2'd2
    } fb_state_e;

    typedef struct packed {
        logic [ADDR_W-1:0]   addr;
        logic [COLOUR_W-1:0] colour;
    } fb_entry_t;

    // y*160 = y*128 + y*32; the result always fits 15 bits for on-screen pixels.
    function automatic logic [ADDR_W-1:0] fb_addr(input logic [7:0] x,
                                                  input logic [6:0] y);
        logic [ADDR_W-1:0] y_w;
        logic [ADDR_W-1:0] x_w;
        y_w = {8'd0, y};
        x_w = {7'd0, x};
        return (y_w << 7) + (y_w << 5) + x_w;
    endfunction

endpackage

// File: rtl/pixel_fifo.sv
// -----------------------------------------------------------------------------
// pixel_fifo
// Small synchronous FIFO holding pending plot entries.
// Ports:
//   clk_i, reset_i   clock, asynchronous active-high reset (empties the FIFO)
//   push_i, data_i   write one entry; ignored when full unless popping too
//   pop_i            remove the head entry; ignored when empty
//   data_o           head entry (valid while empty_o is low)
//   full_o, empty_o  occupancy flags
// A simultaneous push and pop while full is accepted: the slot being written
// is the one the head is leaving, and the head is read before the edge.
// -----------------------------------------------------------------------------
module pixel_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 18
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    // Pointers carry one extra wrap bit to tell full from empty.
    logic [PTR_W:0]   wr_ptr_q;
    logic [PTR_W:0]   rd_ptr_q;
    logic             do_push_s;
    logic             do_pop_s;

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                     (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
    assign data_o  = mem_q[rd_ptr_q[PTR_W-1:0]];

    // Qualify requests against the occupancy flags.
    always_comb begin
        do_pop_s  = pop_i & ~empty_o;
        do_push_s = push_i & (~full_o | do_pop_s);
    end

    // Storage and pointer update.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (do_push_s) begin
                mem_q[wr_ptr_q[PTR_W-1:0]] <= data_i;
                wr_ptr_q <= wr_ptr_q + {{PTR_W{1'b0}}, 1'b1};
            end
            if (do_pop_s) begin
                rd_ptr_q <= rd_ptr_q + {{PTR_W{1'b0}}, 1'b1};
            end
        end
    end

endmodule

// File: rtl/pixel_framebuffer_writer.sv
// -----------------------------------------------------------------------------
// pixel_framebuffer_writer
// Receives plot strobes (x, y, colour), buffers them in a small FIFO as linear
// framebuffer addresses, and writes them to video memory over a valid/ready
// write port. Also sweeps the whole screen to a latched background colour.
// Ports:
//   clk_i, reset_i          clock, asynchronous active-high reset
//   plot_i, x_i, y_i,
//   colour_i                one pixel per cycle while plot_i is high
//   clear_go_i,
//   clear_colour_i          request full-screen clear, colour sampled with it
//   mem_addr_o, mem_data_o,
//   mem_we_o, mem_ready_i   write beat; completes when mem_we_o & mem_ready_i
//   busy_o                  work queued, in flight, pending or clearing
//   clear_done_o            one-cycle pulse after the last clear beat
//   overflow_o              sticky: a plot met a full FIFO
//   dropped_count_o         saturating count of discarded plots
// -----------------------------------------------------------------------------
import pixel_fb_pkg::*;

module pixel_framebuffer_writer #(
    parameter int FIFO_DEPTH = 4,
    parameter int SCREEN_W   = pixel_fb_pkg::SCREEN_W,
    parameter int SCREEN_H   = pixel_fb_pkg::SCREEN_H
) (
    input  logic                clk_i,
    input  logic                reset_i,
    input  logic                plot_i,
    input  logic [7:0]          x_i,
    input  logic [6:0]          y_i,
    input  logic [COLOUR_W-1:0] colour_i,
    input  logic                clear_go_i,
    input  logic [COLOUR_W-1:0] clear_colour_i,
    output logic [ADDR_W-1:0]   mem_addr_o,
    output logic [COLOUR_W-1:0] mem_data_o,
    output logic                mem_we_o,
    input  logic                mem_ready_i,
    output logic                busy_o,
    output logic                clear_done_o,
    output logic                overflow_o,
    output logic [7:0]          dropped_count_o
);

    localparam logic [7:0]        X_LIM   = 8'(SCREEN_W);
    localparam logic [6:0]        Y_LIM   = 7'(SCREEN_H);
    localparam logic [ADDR_W-1:0] FB_LAST = ADDR_W'(FB_WORDS - 1);

    fb_state_e            state_q;
    logic [ADDR_W-1:0]    mem_addr_q;
    logic [COLOUR_W-1:0]  mem_data_q;
    logic                 mem_we_q;
    logic                 clear_done_q;
    logic                 clear_pend_q;   // set by clear_go, held through the sweep
    logic [COLOUR_W-1:0]  clear_colour_q;
    logic                 overflow_q;
    logic                 overflow_d;
    logic [7:0]           dropped_q;
    logic [7:0]           dropped_d;

    fb_entry_t            push_entry_s;
    fb_entry_t            head_entry_s;
    logic [ENTRY_W-1:0]   head_bits_s;
    logic                 fifo_full_s;
    logic                 fifo_empty_s;
    logic                 push_s;
    logic                 pop_s;
    logic                 beat_done_s;
    logic                 in_range_s;
    logic                 blocked_s;
    logic                 drop_s;
    logic                 ovf_s;

    assign head_entry_s = fb_entry_t'(head_bits_s);

    pixel_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .push_i  (push_s),
        .data_i  (push_entry_s),
        .pop_i   (pop_s),
        .data_o  (head_bits_s),
        .full_o  (fifo_full_s),
        .empty_o (fifo_empty_s)
    );

    // Pop decision: IDLE always drains a non-empty FIFO (even with a clear
    // pending, so earlier pixels go out first); WRITE chains the next pixel
    // only on a completed beat with no clear pending.
    always_comb begin
        beat_done_s = mem_we_q & mem_ready_i;
        pop_s       = 1'b0;
        case (state_q)
            ST_IDLE:  pop_s = ~fifo_empty_s;
            ST_WRITE: pop_s = beat_done_s & ~fifo_empty_s & ~clear_pend_q;
            ST_CLEAR: pop_s = 1'b0;
            default:  pop_s = 1'b0;
        endcase
    end

    // Plot acceptance: range check first (counted), then clear blocking
    // (silent), then FIFO capacity after this cycle's pop (counted, sticky flag).
    always_comb begin
        in_range_s          = (x_i < X_LIM) && (y_i < Y_LIM);
        blocked_s           = clear_pend_q | clear_go_i;
        push_entry_s.addr   = fb_addr(x_i, y_i);
        push_entry_s.colour = colour_i;
        push_s              = 1'b0;
        drop_s              = 1'b0;
        ovf_s               = 1'b0;
        if (plot_i) begin
            if (!in_range_s) begin
                drop_s = 1'b1;
            end else if (blocked_s) begin
                drop_s = 1'b0;
            end else if (fifo_full_s && !pop_s) begin
                drop_s = 1'b1;
                ovf_s  = 1'b1;
            end else begin
                push_s = 1'b1;
            end
        end else begin
            push_s = 1'b0;
        end
    end

    // Next values of the sticky overflow flag and saturating drop counter.
    always_comb begin
        overflow_d = overflow_q | ovf_s;
        if (drop_s && (dropped_q != 8'hFF)) begin
            dropped_d = dropped_q + 8'd1;
        end else begin
            dropped_d = dropped_q;
        end
    end

    // Drop statistics registers.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            overflow_q <= 1'b0;
            dropped_q  <= 8'd0;
        end else begin
            overflow_q <= overflow_d;
            dropped_q  <= dropped_d;
        end
    end

    // Writer FSM with registered memory-port outputs and clear bookkeeping.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q        <= ST_IDLE;
            mem_addr_q     <= '0;
            mem_data_q     <= '0;
            mem_we_q       <= 1'b0;
            clear_done_q   <= 1'b0;
            clear_pend_q   <= 1'b0;
            clear_colour_q <= '0;
        end else begin
            clear_done_q <= 1'b0;
            // A new request is only taken when nothing is pending or sweeping.
            if (clear_go_i && !clear_pend_q) begin
                clear_pend_q   <= 1'b1;
                clear_colour_q <= clear_colour_i;
            end
            case (state_q)
                ST_IDLE: begin
                    if (clear_pend_q && fifo_empty_s) begin
                        state_q    <= ST_CLEAR;
                        mem_addr_q <= '0;
                        mem_data_q <= clear_colour_q;
                        mem_we_q   <= 1'b1;
                    end else if (!fifo_empty_s) begin
                        state_q    <= ST_WRITE;
                        mem_addr_q <= head_entry_s.addr;
                        mem_data_q <= head_entry_s.colour;
                        mem_we_q   <= 1'b1;
                    end
                end
                ST_WRITE: begin
                    if (beat_done_s) begin
                        if (pop_s) begin
                            mem_addr_q <= head_entry_s.addr;
                            mem_data_q <= head_entry_s.colour;
                        end else begin
                            mem_we_q <= 1'b0;
                            state_q  <= ST_IDLE;
                        end
                    end
                end
                ST_CLEAR: begin
                    if (beat_done_s) begin
                        if (mem_addr_q == FB_LAST) begin
                            mem_we_q     <= 1'b0;
                            clear_done_q <= 1'b1;
                            clear_pend_q <= 1'b0;
                            state_q      <= ST_IDLE;
                        end else begin
                            mem_addr_q <= mem_addr_q + 15'd1;
                        end
                    end
                end
                default: begin
                    state_q  <= ST_IDLE;
                    mem_we_q <= 1'b0;
                end
            endcase
        end
    end

    assign mem_addr_o      = mem_addr_q;
    assign mem_data_o      = mem_data_q;
    assign mem_we_o        = mem_we_q;
    assign clear_done_o    = clear_done_q;
    assign overflow_o      = overflow_q;
    assign dropped_count_o = dropped_q;
    assign busy_o          = ~fifo_empty_s | mem_we_q | clear_pend_q |
                             (state_q != ST_IDLE);

endmodule
